// File: rtl/tile_blitter.sv
// Tile blitter: copies a TILE_W x TILE_H tile of palette indices from the tile ROM into the frame buffer, clipping at the screen edges.
// Optional macro TILE_TRANSPARENCY_EN suppresses writes of TRANSPARENT_ID pixels.
module tile_blitter #(
   parameter int unsigned TILE_W         = 32,
   parameter int unsigned TILE_H         = 32,
   parameter int unsigned FB_WIDTH       = 640,
   parameter int unsigned FB_HEIGHT      = 480,
   parameter int unsigned ROM_LATENCY    = 2,
   parameter logic [7:0]  TRANSPARENT_ID = 8'h00
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        START,
   input  logic [7:0]  TILE_ID,
   input  logic [9:0]  TILE_X,
   input  logic [9:0]  TILE_Y,
   output logic        BUSY,
   output logic        DONE,
   output logic [17:0] ROM_ADDR,
   output logic        ROM_EN,
   input  logic [7:0]  ROM_DOUT,
   output logic        FB_WE,
   output logic [20:0] FB_ADDR,
   output logic [7:0]  FB_DOUT,
   input  logic        FB_READY
);

   localparam int unsigned CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int unsigned RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int          L  = int'(ROM_LATENCY);
`ifdef TILE_TRANSPARENCY_EN
   localparam bit TRANSP_EN = 1'b1;
`else
   localparam bit TRANSP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   col_q;
   logic [RW-1:0]   row_q;
   logic [9:0]      x_q, y_q;
   logic [20:0]     row_base_q;
   logic [17:0]     rom_addr_q;
   logic            s0_valid_q, s0_inb_q;
   logic [20:0]     s0_fbaddr_q;
   logic [2:0]      drain_q;
   logic            busy_q, done_q;
   logic            we_pipe   [1:L];
   logic [20:0]     addr_pipe [1:L];

   logic            advance, pipe_en, accept, last_pix, col_wrap;
   logic [CW-1:0]   ncol;
   logic [RW-1:0]   nrow;
   logic [20:0]     nbase, nfb, base0, fb0;
   logic            ninb, inb0;

   assign advance  = FB_READY;
   assign pipe_en  = advance && busy_q;
   assign accept   = (state_q == IDLE) && START;
   assign col_wrap = (col_q == CW'(TILE_W - 1));
   assign last_pix = col_wrap && (row_q == RW'(TILE_H - 1));

   // Next pixel in raster order; row base steps by one stride at each row wrap
   assign ncol  = col_wrap ? '0 : col_q + CW'(1);
   assign nrow  = col_wrap ? row_q + RW'(1) : row_q;
   assign nbase = col_wrap ? row_base_q + 21'(FB_WIDTH) : row_base_q;
   assign nfb   = nbase + 21'(x_q) + 21'(ncol);
   assign ninb  = ((11'(x_q) + 11'(ncol)) < 11'(FB_WIDTH)) &&
                  ((11'(y_q) + 11'(nrow)) < 11'(FB_HEIGHT));

   assign base0 = 21'(TILE_Y) * 21'(FB_WIDTH);
   assign fb0   = base0 + 21'(TILE_X);
   assign inb0  = (11'(TILE_X) < 11'(FB_WIDTH)) && (11'(TILE_Y) < 11'(FB_HEIGHT));

   always_ff @(posedge Clk) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (START) state_d = RUN;
         RUN:     if (advance && last_pix) state_d = DRAIN;
         DRAIN:   if (advance && (drain_q == 3'(ROM_LATENCY - 1))) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address generation, issue stage and drain counter
   always_ff @(posedge Clk) begin
      if (Reset) begin
         col_q       <= '0;
         row_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         row_base_q  <= '0;
         rom_addr_q  <= '0;
         s0_valid_q  <= 1'b0;
         s0_inb_q    <= 1'b0;
         s0_fbaddr_q <= '0;
         drain_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         busy_q <= (state_d != IDLE);
         done_q <= (state_d == FIN);
         if (accept) begin
            x_q         <= TILE_X;
            y_q         <= TILE_Y;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= base0;
            rom_addr_q  <= 18'(TILE_ID) * 18'(TILE_W * TILE_H);
            s0_valid_q  <= 1'b1;
            s0_inb_q    <= inb0;
            s0_fbaddr_q <= fb0;
         end else if ((state_q == RUN) && advance) begin
            if (last_pix) begin
               s0_valid_q <= 1'b0;
               drain_q    <= '0;
            end else begin
               col_q       <= ncol;
               row_q       <= nrow;
               row_base_q  <= nbase;
               rom_addr_q  <= rom_addr_q + 18'd1;
               s0_fbaddr_q <= nfb;
               s0_inb_q    <= ninb;
            end
         end else if ((state_q == DRAIN) && advance) begin
            drain_q <= drain_q + 3'd1;
         end
      end
   end

   // Write-qualifier/address pipeline, aligned with the ROM read latency
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 1; i <= L; i++) begin
            we_pipe[i]   <= 1'b0;
            addr_pipe[i] <= '0;
         end
      end else if (pipe_en) begin
         for (int i = L; i > 1; i--) begin
            we_pipe[i]   <= we_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
         we_pipe[1]   <= s0_valid_q && s0_inb_q;
         addr_pipe[1] <= s0_fbaddr_q;
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ROM_ADDR = rom_addr_q;
   assign ROM_EN   = pipe_en;
   assign FB_WE    = we_pipe[L] && (!TRANSP_EN || (ROM_DOUT != TRANSPARENT_ID));
   assign FB_ADDR  = addr_pipe[L];
   assign FB_DOUT  = FB_WE ? ROM_DOUT : 8'h00;

endmodule

// File: tb/tb_tile_blitter.sv
// Randomized scoreboard bench for tile_blitter: a ROM model feeds the DUT, a reference model predicts every frame-buffer write and the DONE cycle.
module tb_tile_blitter;
   localparam int L = 2;

   logic        Clk = 1'b0, Reset = 1'b1, START = 1'b0, FB_READY = 1'b1;
   logic [7:0]  TILE_ID = '0;
   logic [9:0]  TILE_X = '0, TILE_Y = '0;
   logic        BUSY, DONE, ROM_EN, FB_WE;
   logic [17:0] ROM_ADDR;
   logic [7:0]  ROM_DOUT, FB_DOUT;
   logic [20:0] FB_ADDR;

   tile_blitter dut (
      .Clk(Clk), .Reset(Reset), .START(START), .TILE_ID(TILE_ID), .TILE_X(TILE_X), .TILE_Y(TILE_Y),
      .BUSY(BUSY), .DONE(DONE), .ROM_ADDR(ROM_ADDR), .ROM_EN(ROM_EN), .ROM_DOUT(ROM_DOUT),
      .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DOUT(FB_DOUT), .FB_READY(FB_READY)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int vectors = 0, errors = 0;
   int rom_mode = 0, stall_mode = 0;
   int t0 = 0, stalls = 0, wcnt = 0, wexp = 0;
   bit active = 1'b0;
   int          eaddr[$];
   logic [7:0]  edata[$];
   int          ea;
   logic [7:0]  ed;

   function automatic logic [7:0] rom_fn(input logic [17:0] a);
      int v = int'(a);
      if (rom_mode == 1) return (a[4:0] == 5'd5) ? 8'h2A : 8'h00;
      return 8'((v * 37) ^ (v >> 9) ^ 85);
   endfunction

   // Tile ROM: L-deep read pipeline advancing only on ROM_EN
   logic [7:0] rp [L];
   initial for (int i = 0; i < L; i++) rp[i] = 8'h00;
   always @(posedge Clk) if (ROM_EN) begin
      rp[0] <= rom_fn(ROM_ADDR);
      for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
   end
   assign ROM_DOUT = rp[L-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Frame-buffer backpressure driver
   always @(posedge Clk) begin
      #2;
      case (stall_mode)
         1:       FB_READY = !(active && (cyc - t0) >= 101 + L && (cyc - t0) < 106 + L);
         2:       FB_READY = ($urandom_range(0, 7) != 0);
         default: FB_READY = 1'b1;
      endcase
   end

   // Monitor: pops accepted writes; DONE expected after 1025+L cycles plus stalls before it
   always @(negedge Clk) begin
      if (FB_WE && FB_READY) begin
         if (eaddr.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_write: got write at addr %0d, required none", FB_ADDR);
         end else begin
            ea = eaddr.pop_front();
            ed = edata.pop_front();
            chk("fb_addr", 32'(FB_ADDR), ea);
            chk("fb_dout", 32'(FB_DOUT), 32'(ed));
            wcnt++;
         end
      end
      if (active && (cyc - t0) >= 1) begin
         if ((cyc - t0) == 1025 + L + stalls) begin
            chk("done_cycle", 32'(DONE), 1);
            chk("write_count", wcnt, wexp);
            active = 1'b0;
         end else begin
            if (DONE) begin
               vectors++; errors++;
               $display("FAIL early_done: got DONE at cycle %0d, required cycle >= %0d", cyc - t0, 1025 + L + stalls);
            end
            if (!FB_READY) stalls++;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_rom_en"}, 32'(ROM_EN), 0);
      chk({tag, "_fb_we"}, 32'(FB_WE), 0);
      chk({tag, "_rom_addr"}, 32'(ROM_ADDR), 0);
      chk({tag, "_fb_addr"}, 32'(FB_ADDR), 0);
      chk({tag, "_fb_dout"}, 32'(FB_DOUT), 0);
   endtask

   // special: 0 none, 1 ignored START pulse at pixel 500, 2 reset at pixel 500
   task automatic blit(input logic [7:0] id, input int x, input int y, input int smode, input int special);
      logic [7:0] d;
      eaddr.delete(); edata.delete(); wexp = 0;
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            if (x + c < 640 && y + r < 480) begin
               d = rom_fn(18'(int'(id) * 1024 + r * 32 + c));
`ifdef TILE_TRANSPARENCY_EN
               if (d == 8'h00) continue;
`endif
               eaddr.push_back((y + r) * 640 + x + c);
               edata.push_back(d);
               wexp++;
            end
      @(posedge Clk); #1;
      START = 1'b1; TILE_ID = id; TILE_X = 10'(x); TILE_Y = 10'(y);
      t0 = cyc; stalls = 0; wcnt = 0; stall_mode = smode; active = 1'b1;
      @(posedge Clk); #1;
      START = 1'b0; TILE_ID = 8'($urandom); TILE_X = 10'($urandom); TILE_Y = 10'($urandom);
      chk("rom_addr_first", 32'(ROM_ADDR), int'(id) * 1024);
      chk("busy_cycle1", 32'(BUSY), 1);
      if (special != 0) begin
         while (cyc - t0 < 500) begin @(posedge Clk); #1; end
         if (special == 1) begin
            START = 1'b1; TILE_ID = ~id; TILE_X = 10'(x + 7); TILE_Y = 10'(y + 3);
            @(posedge Clk); #1;
            START = 1'b0;
         end else begin
            Reset = 1'b1;
            @(posedge Clk); #1;
            Reset = 1'b0;
            active = 1'b0;
            eaddr.delete(); edata.delete();
            check_idle_outputs("after_reset");
            return;
         end
      end
      for (int k = 0; k < 4000 && active; k++) begin @(posedge Clk); #1; end
      if (active) begin
         vectors++; errors++;
         $display("FAIL blit_timeout: got no completion, required DONE within 4000 cycles");
         active = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(posedge Clk);
      #1;
      check_idle_outputs("reset");
      Reset = 1'b0;
      blit(8'd3, 64, 32, 0, 0);
      blit(8'd7, 624, 464, 0, 0);
      blit(8'd10, 100, 50, 1, 0);
      rom_mode = 1;
      blit(8'd0, 0, 0, 0, 0);
      rom_mode = 0;
      for (int i = 0; i < 6; i++)
         blit(8'($urandom), $urandom_range(0, 660), $urandom_range(0, 500), 2, 0);
      blit(8'd5, 200, 100, 0, 1);
      blit(8'd9, 300, 200, 0, 2);
      blit(8'd12, 10, 10, 0, 0);
      repeat (3) @(posedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, required completion within 2000000 time units");
      $fatal(1);
   end
endmodule

// File: doc/tile_blitter.md
# tile_blitter

Copies one 32×32 tile of 8-bit palette indices from the tile ROM into the 640×480 frame buffer at a pixel origin. It is the write-side producer for the frame-buffer RAM: the scan-out stage reads the same RAM by raster address, and `tile_blitter` fills it. It is a start/busy/done engine driven by the game-logic sequencer, with a pipelined ROM read, frame-buffer backpressure and screen-edge clipping.

## Interface
- `TILE_W`, 32: tile width in pixels; power of two.
- `TILE_H`, 32: tile height in pixels.
- `FB_WIDTH`, 640: frame-buffer line stride and horizontal clip limit.
- `FB_HEIGHT`, 480: vertical clip limit.
- `ROM_LATENCY`, 2: tile-ROM read latency in enabled cycles; range 1–4.
- `TRANSPARENT_ID`, 8'h00: color ID that is never written (see Configuration).

Ports:
- `Clk`  in  1  sole clock; all logic is on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `START`  in  1  request a blit; sampled only in IDLE.
- `TILE_ID`  in  8  tile index; latched on accept.
- `TILE_X`  in  10  pixel X of the tile's top-left corner; latched on accept.
- `TILE_Y`  in  10  pixel Y of the tile's top-left corner; latched on accept.
- `BUSY`  out  1  high from the cycle after accept through the DONE cycle.
- `DONE`  out  1  one-cycle completion pulse.
- `ROM_ADDR`  out  18  `TILE_ID*TILE_W*TILE_H + row*TILE_W + col`.
- `ROM_EN`  out  1  ROM clock enable; equal to the internal advance signal.
- `ROM_DOUT`  in  8  color ID, valid `ROM_LATENCY` enabled cycles after its address.
- `FB_WE`  out  1  frame-buffer write strobe.
- `FB_ADDR`  out  21  `(TILE_Y+row)*FB_WIDTH + (TILE_X+col)`.
- `FB_DOUT`  out  8  color ID to write.
- `FB_READY`  in  1  the frame buffer accepts this cycle's write. Low stalls the block.

## Operation
- FSM states:
  - IDLE: `START`=1 latches `TILE_ID`, `TILE_X` and `TILE_Y`, clears `row`/`col`, and moves to RUN.
  - RUN: one ROM address is issued per advance, `col` first, then `row`. After the address for (TILE_H-1, TILE_W-1) is issued, move to DRAIN.
  - DRAIN: lasts `ROM_LATENCY` advances, which flush the pipeline; then move to FIN.
  - FIN: `DONE`=1 for one cycle, then return to IDLE.
- Advance signal: `advance = FB_READY`. While `advance` is low, `row`, `col`, the state, the drain counter, every pipeline stage and `ROM_EN` hold.
- Valid/address pipeline:
  - A valid bit travels alongside each address through a `ROM_LATENCY`-deep pipeline.
  - The FB row base starts at `TILE_Y*FB_WIDTH`, computed once in the accept cycle.
  - The row base steps by `FB_WIDTH` at each row wrap. No per-pixel multiply.
- Write qualification: `FB_WE` = pipeline valid AND `TILE_X+col < FB_WIDTH` AND `TILE_Y+row < FB_HEIGHT`. The comparison uses 11-bit sums so there is no wrap-around.
- Clipped pixels still consume a cycle; the cycle count is fixed.
- `FB_DOUT` = `ROM_DOUT` when `FB_WE`=1, else 0.
- A `START` pulse while BUSY is ignored. It is not queued.
- `START` held high across FIN starts a new blit from the IDLE cycle that follows.
- Reset (any state, including mid-blit): the next edge returns to IDLE and clears the pipeline valids. No further `FB_WE` is issued. The partially written tile is left as is.
- Reset values: `BUSY`, `DONE`, `ROM_EN`, `FB_WE` = 0; `ROM_ADDR`, `FB_ADDR`, `FB_DOUT` = 0.

## Timing
- Let E0 be the edge that samples `START`=1 in IDLE, and L = `ROM_LATENCY`. With no stalls:
  - Cycle 1: ROM address for pixel 0.
  - Cycle 1+k: ROM address for pixel k.
  - Cycle 1+k+L: `FB_WE` for pixel k.
  - Last write is in cycle 1024+L.
  - `DONE` is in cycle 1025+L.
  - Back in IDLE at cycle 1026+L.
- Each cycle with `FB_READY`=0 while BUSY adds exactly one cycle. A stalled write keeps `FB_WE`, `FB_ADDR` and `FB_DOUT` stable until a cycle with `FB_READY`=1.
- There is no combinational path from `START` or `FB_READY` to `ROM_ADDR`, `FB_ADDR` or `FB_DOUT`. `ROM_EN` is combinational from `FB_READY`.

## Configuration
- `TILE_TRANSPARENCY_EN` defined: additionally qualify `FB_WE` with `ROM_DOUT != TRANSPARENT_ID`. The background shows through, which is needed for hero and monster sprites. Cycle count is unchanged.
- `TILE_TRANSPARENCY_EN` undefined: every in-bounds pixel is written, including `TRANSPARENT_ID`.

## Test plan
- TILE_ID=3, X=64, Y=32, `FB_READY`=1, L=2:
  - First ROM_ADDR=3072 in cycle 1.
  - First write FB_ADDR=20544 in cycle 3.
  - Exactly 1024 writes.
  - DONE in cycle 1027.
- X=624, Y=464: only 16×16=256 writes. Max FB_ADDR=479×640+639=307199. DONE cycle is unchanged.
- `FB_READY` low for 5 cycles at pixel 100: the write at FB_ADDR held stable for those 5 cycles, no duplicate or lost writes, DONE 5 cycles later.
- ROM data all 0x00 except 0x2A at col=5 for every row:
  - With `TILE_TRANSPARENCY_EN`: 32 writes.
  - Without it: 1024 writes.
- START pulsed at pixel 500: ignored and latches unchanged. Reset at pixel 500: no FB_WE after the reset edge, all outputs 0, and a new START is accepted the next cycle.
